mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 42 ++++
 rtl/mem_lsu_align.sv | 54 +++++
 rtl/mem_lsu.sv | 195 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: memory-op and FSM encodings,
// reset constants and small op-classification helpers.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } memop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'd0;

  function automatic logic isLoad(input memop_e op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic isStore(input memop_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  // Halfwords need an even offset, words a zero offset.
  function automatic logic isMisaligned(input memop_e op, input logic [1:0] off);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return off[0];
      MEM_LW, MEM_SW:          return off != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane logic: byte enables, store-data replication into lanes, and
// load lane selection with sign/zero extension (little-endian).
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  memop_e      memop_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [1:0]  offEff;
  logic [15:0] laneData;

  // Misaligned offsets collapse to the natural boundary of the access size.
  always_comb begin
    offEff = 2'b00;
    be_o   = 4'b0000;
    case (memop_i)
      MEM_LB, MEM_LBU, MEM_SB: begin
        offEff = off_i;
        be_o   = 4'b0001 << off_i;
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        offEff = {off_i[1], 1'b0};
        be_o   = off_i[1] ? 4'b1100 : 4'b0011;
      end
      MEM_LW, MEM_SW: begin
        offEff = 2'b00;
        be_o   = 4'b1111;
      end
      default: ;
    endcase

    laneData = 16'(rdata_i >> {offEff, 3'b000});
    wdata_o  = ZeroWord;
    ldata_o  = ZeroWord;
    case (memop_i)
      MEM_LB:  ldata_o = {{24{laneData[7]}}, laneData[7:0]};
      MEM_LBU: ldata_o = {24'h000000, laneData[7:0]};
      MEM_LH:  ldata_o = {{16{laneData[15]}}, laneData};
      MEM_LHU: ldata_o = {16'h0000, laneData};
      MEM_LW:  ldata_o = rdata_i;
      MEM_SB:  wdata_o = {4{sdata_i[7:0]}};
      MEM_SH:  wdata_o = {2{sdata_i[15:0]}};
      MEM_SW:  wdata_o = sdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit with a single outstanding data-bus access and an ack timeout.
// Define MEM_LSU_ALIGN_EXC_EN to trap misaligned accesses via align_exc_o.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            memop_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [31:0]           sdata_i,
  output logic                  stall_o,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [3:0]            dbus_be_o,
  output logic [ADDR_W-1:0]     dbus_addr_o,
  output logic [31:0]           dbus_wdata_o,
  input  logic                  dbus_ack_i,
  input  logic [31:0]           dbus_rdata_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  valid_o,
`ifdef MEM_LSU_ALIGN_EXC_EN
  output logic                  align_exc_o,
`endif
  output logic                  bus_err_o
);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  memop_e                latOp_q, latOp_d;
  logic [ADDR_W-1:0]     latAddr_q, latAddr_d;
  logic [31:0]           latSdata_q, latSdata_d;
  logic [REG_ADDR_W-1:0] latWd_q, latWd_d;
  logic                  latWreg_q, latWreg_d;
  logic [31:0]           latWdata_q, latWdata_d;
  logic [REG_ADDR_W-1:0] wd_q, wd_d;
  logic                  wreg_q, wreg_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic                  isIdle, misal, reqActive, timeout, done;
  memop_e                curOp;
  logic [ADDR_W-1:0]     curAddr;
  logic [31:0]           curSdata, curWdata;
  logic [REG_ADDR_W-1:0] curWd;
  logic                  curWreg;
  logic [3:0]            alignBe;
  logic [31:0]           alignWdata, alignLdata;

  mem_lsu_align u_align (
    .memop_i (curOp),
    .off_i   (curAddr[1:0]),
    .sdata_i (curSdata),
    .rdata_i (dbus_rdata_i),
    .be_o    (alignBe),
    .wdata_o (alignWdata),
    .ldata_o (alignLdata)
  );

  // In WAIT the bus is driven from the latched request so it never changes mid-access.
  always_comb begin
    isIdle   = (state_q == ST_IDLE);
    curOp    = isIdle ? memop_e'(memop_i) : latOp_q;
    curAddr  = isIdle ? addr_i  : latAddr_q;
    curSdata = isIdle ? sdata_i : latSdata_q;
    curWd    = isIdle ? wd_i    : latWd_q;
    curWreg  = isIdle ? wreg_i  : latWreg_q;
    curWdata = isIdle ? wdata_i : latWdata_q;
    misal    = 1'b0;
`ifdef MEM_LSU_ALIGN_EXC_EN
    misal    = isIdle && in_valid_i && isMisaligned(curOp, curAddr[1:0]);
`endif
    reqActive = rst && (!isIdle || (in_valid_i && curOp != MEM_NONE && !misal));
    timeout   = !isIdle && (cnt_q == 8'(TIMEOUT_CYC - 1)) && !dbus_ack_i;
    done      = reqActive && dbus_ack_i;
    stall_o   = reqActive && !(dbus_ack_i || timeout);

    dbus_req_o   = reqActive;
    dbus_we_o    = reqActive && isStore(curOp);
    dbus_be_o    = reqActive ? alignBe : 4'b0000;
    dbus_addr_o  = reqActive ? {curAddr[ADDR_W-1:2], 2'b00} : '0;
    dbus_wdata_o = reqActive ? alignWdata : ZeroWord;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latOp_d    = latOp_q;
    latAddr_d  = latAddr_q;
    latSdata_d = latSdata_q;
    latWd_d    = latWd_q;
    latWreg_d  = latWreg_q;
    latWdata_d = latWdata_q;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    if (isIdle) begin
      if (reqActive && !dbus_ack_i) begin
        state_d    = ST_WAIT;
        cnt_d      = 8'd0;
        latOp_d    = curOp;
        latAddr_d  = addr_i;
        latSdata_d = sdata_i;
        latWd_d    = wd_i;
        latWreg_d  = wreg_i;
        latWdata_d = wdata_i;
      end
    end else if (dbus_ack_i || timeout) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    if (done) begin
      valid_d = 1'b1;
      wd_d    = curWd;
      wreg_d  = curWreg;
      wdata_d = isLoad(curOp) ? alignLdata : curWdata;
    end else if (timeout) begin
      valid_d = 1'b1;
      err_d   = 1'b1;
      wd_d    = curWd;
      wreg_d  = 1'b0;
    end else if (isIdle && in_valid_i && (curOp == MEM_NONE || misal)) begin
      valid_d = 1'b1;
      wd_d    = wd_i;
      wreg_d  = wreg_i && !misal;
      wdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      latOp_q    <= MEM_NONE;
      latAddr_q  <= '0;
      latSdata_q <= ZeroWord;
      latWd_q    <= REG_ADDR_W'(NOPRegAddr);
      latWreg_q  <= 1'b0;
      latWdata_q <= ZeroWord;
      wd_q       <= REG_ADDR_W'(NOPRegAddr);
      wreg_q     <= 1'b0;
      wdata_q    <= ZeroWord;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      latOp_q    <= latOp_d;
      latAddr_q  <= latAddr_d;
      latSdata_q <= latSdata_d;
      latWd_q    <= latWd_d;
      latWreg_q  <= latWreg_d;
      latWdata_q <= latWdata_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

`ifdef MEM_LSU_ALIGN_EXC_EN
  logic exc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exc_q <= 1'b0;
    else      exc_q <= misal;
  end

  assign align_exc_o = exc_q;
`endif

  assign wd_o      = wd_q;
  assign wreg_o    = wreg_q;
  assign wdata_o   = wdata_q;
  assign valid_o   = valid_q;
  assign bus_err_o = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed-vector bench for mem_lsu: table of transactions with hand-computed
// results plus hand-written reset and idle-ack sequences.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  wd = '0;
  logic        wreg = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  memop = '0;
  logic [31:0] addr = '0;
  logic [31:0] sdata = '0;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        stall, dreq, dwe, validO, wregO, errO;
  logic [3:0]  dbe;
  logic [31:0] daddr, dwdata, wdataO;
  logic [4:0]  wdO;
`ifdef MEM_LSU_ALIGN_EXC_EN
  logic        excO;
`endif

  mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .wd_i(wd), .wreg_i(wreg),
    .wdata_i(wdata), .memop_i(memop), .addr_i(addr), .sdata_i(sdata),
    .stall_o(stall), .dbus_req_o(dreq), .dbus_we_o(dwe), .dbus_be_o(dbe),
    .dbus_addr_o(daddr), .dbus_wdata_o(dwdata), .dbus_ack_i(ack),
    .dbus_rdata_i(rdata), .wd_o(wdO), .wreg_o(wregO), .wdata_o(wdataO),
    .valid_o(validO),
`ifdef MEM_LSU_ALIGN_EXC_EN
    .align_exc_o(excO),
`endif
    .bus_err_o(errO)
  );

  always #5 clk = ~clk;

  typedef struct {
    memop_e      op;
    logic [31:0] addr, sdata, rdata, wdata;
    logic [4:0]  wd;
    logic        wreg;
    int          ackWait;
    logic [3:0]  expBe;
    logic [31:0] expDwdata;
    logic        expWe;
    logic [31:0] expWdata;
    logic        expWreg, expErr;
    int          expReq, expStall;
    logic        expExc;
  } vec_t;

  vec_t vecs[11];
  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] beMask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    int reqCnt = 0;
    int stallCnt = 0;
    bit seen = 0;
    in_valid = 1'b1; memop = v.op; addr = v.addr; sdata = v.sdata;
    wd = v.wd; wreg = v.wreg; wdata = v.wdata; rdata = v.rdata;
    for (int c = 0; c < 40 && !seen; c++) begin
      ack = (v.ackWait == c);
      #1;
      if (dreq) begin
        reqCnt++;
        checkOutput($sformatf("v%0d c%0d be", idx, c), 32'(dbe), 32'(v.expBe));
        checkOutput($sformatf("v%0d c%0d addr", idx, c), daddr, v.addr & 32'hFFFF_FFFC);
        checkOutput($sformatf("v%0d c%0d we", idx, c), 32'(dwe), 32'(v.expWe));
        if (v.expWe)
          checkOutput($sformatf("v%0d c%0d dwdata", idx, c), dwdata & beMask(v.expBe), v.expDwdata);
      end
      if (stall) stallCnt++;
      @(posedge clk); #1;
      in_valid = 1'b0; memop = MEM_NONE; ack = 1'b0;
      if (validO) seen = 1;
      else @(negedge clk);
    end
    checkOutput($sformatf("v%0d completed", idx), 32'(seen), 32'd1);
    checkOutput($sformatf("v%0d reqCycles", idx), 32'(reqCnt), 32'(v.expReq));
    checkOutput($sformatf("v%0d stallCycles", idx), 32'(stallCnt), 32'(v.expStall));
    checkOutput($sformatf("v%0d wd_o", idx), 32'(wdO), 32'(v.wd));
    checkOutput($sformatf("v%0d wreg_o", idx), 32'(wregO), 32'(v.expWreg));
    if (!v.expErr) checkOutput($sformatf("v%0d wdata_o", idx), wdataO, v.expWdata);
    checkOutput($sformatf("v%0d bus_err_o", idx), 32'(errO), 32'(v.expErr));
`ifdef MEM_LSU_ALIGN_EXC_EN
    checkOutput($sformatf("v%0d align_exc_o", idx), 32'(excO), 32'(v.expExc));
`endif
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d valid pulse ends", idx), 32'(validO), 32'd0);
    checkOutput($sformatf("v%0d bus_err clears", idx), 32'(errO), 32'd0);
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " req"}, 32'(dreq), 32'd0);
    checkOutput({tag, " stall"}, 32'(stall), 32'd0);
    checkOutput({tag, " we"}, 32'(dwe), 32'd0);
    checkOutput({tag, " be"}, 32'(dbe), 32'd0);
    checkOutput({tag, " daddr"}, daddr, 32'd0);
    checkOutput({tag, " dwdata"}, dwdata, 32'd0);
    checkOutput({tag, " wd_o"}, 32'(wdO), 32'd0);
    checkOutput({tag, " wreg_o"}, 32'(wregO), 32'd0);
    checkOutput({tag, " wdata_o"}, wdataO, 32'd0);
    checkOutput({tag, " valid_o"}, 32'(validO), 32'd0);
    checkOutput({tag, " bus_err_o"}, 32'(errO), 32'd0);
  endtask

  initial begin
    //           op        addr          sdata         rdata         wdata         wd    wr ack  be     dwdata        we  expWdata      wr  err req st exc
    vecs[0]  = '{MEM_NONE, 32'h0,        32'h0,        32'h0,        32'h0000_1234, 5'd3, 1, -1, 4'h0, 32'h0,        0, 32'h0000_1234, 1, 0, 0, 0, 0};
    vecs[1]  = '{MEM_LB,   32'h1003,     32'h0,        32'h80FF_0000, 32'h0,       5'd5, 1,  3, 4'h8, 32'h0,        0, 32'hFFFF_FF80, 1, 0, 4, 3, 0};
    vecs[2]  = '{MEM_SH,   32'h2002,     32'h0000_ABCD, 32'h0,       32'h55,       5'd6, 0,  0, 4'hC, 32'hABCD_0000, 1, 32'h55,       0, 0, 1, 0, 0};
    vecs[3]  = '{MEM_LW,   32'h4000,     32'h0,        32'h0,        32'h0,        5'd9, 1, -1, 4'hF, 32'h0,        0, 32'h0,        0, 1, 5, 4, 0};
    vecs[4]  = '{MEM_LW,   32'h4004,     32'h0,        32'hDEAD_BEEF, 32'h0,       5'd10, 1, 4, 4'hF, 32'h0,        0, 32'hDEAD_BEEF, 1, 0, 5, 4, 0};
    vecs[5]  = '{MEM_LBU,  32'h1001,     32'h0,        32'h1234_9A78, 32'h0,       5'd11, 1, 1, 4'h2, 32'h0,        0, 32'h0000_009A, 1, 0, 2, 1, 0};
    vecs[6]  = '{MEM_LHU,  32'h1002,     32'h0,        32'h8001_FFFF, 32'h0,       5'd12, 1, 0, 4'hC, 32'h0,        0, 32'h0000_8001, 1, 0, 1, 0, 0};
    vecs[7]  = '{MEM_LH,   32'h1000,     32'h0,        32'h0001_8765, 32'h0,       5'd13, 1, 2, 4'h3, 32'h0,        0, 32'hFFFF_8765, 1, 0, 3, 2, 0};
    vecs[8]  = '{MEM_SB,   32'h3002,     32'h0000_00A5, 32'h0,       32'h77,       5'd14, 1, 1, 4'h4, 32'h00A5_0000, 1, 32'h77,       1, 0, 2, 1, 0};
    vecs[9]  = '{MEM_SW,   32'h3000,     32'hCAFE_F00D, 32'h0,       32'h1,        5'd15, 1, 0, 4'hF, 32'hCAFE_F00D, 1, 32'h1,        1, 0, 1, 0, 0};
`ifdef MEM_LSU_ALIGN_EXC_EN
    vecs[10] = '{MEM_LW,   32'h3001,     32'h0,        32'h0,        32'h99,       5'd16, 1, 0, 4'h0, 32'h0,        0, 32'h99,       0, 0, 0, 0, 1};
`else
    vecs[10] = '{MEM_LH,   32'h1003,     32'h0,        32'hF00D_1234, 32'h0,       5'd16, 1, 0, 4'hC, 32'h0,        0, 32'hFFFF_F00D, 1, 0, 1, 0, 0};
`endif

    // Reset state, with a load presented that must not reach the bus.
    in_valid = 1'b1; memop = MEM_LW; addr = 32'h100;
    #3;
    checkAllZero("reset");
    in_valid = 1'b0; memop = MEM_NONE;
    @(negedge clk); rst = 1'b1;

    // Ack with no request pending is ignored.
    ack = 1'b1;
    #1;
    checkOutput("idleAck req", 32'(dreq), 32'd0);
    checkOutput("idleAck stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    checkOutput("idleAck valid", 32'(validO), 32'd0);
    ack = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

    // Reset in the middle of a WAIT abandons the access.
    in_valid = 1'b1; memop = MEM_LW; addr = 32'h5000; wd = 5'd7; wreg = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; memop = MEM_NONE;
    checkOutput("midWait req held", 32'(dreq), 32'd1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    checkAllZero("midWait reset");
    @(negedge clk); rst = 1'b1;
    #1;
    checkOutput("afterReset req", 32'(dreq), 32'd0);
    @(posedge clk); #1;
    checkOutput("afterReset valid", 32'(validO), 32'd0);
    checkOutput("afterReset req2", 32'(dreq), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
